// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: groups the core-side control, target buses, the
// instruction-memory handshake and the status outputs of pc_fetch_ctrl.
// The master modport is the view of the PC unit itself. The slave modport is
// the view of the surrounding core and memory.
// Optional macro: PC_C_EXT_EN adds the IS_C (16-bit instruction) signal.
interface pc_fetch_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  // core control and redirect targets
  logic             PC_WRITE;
  logic [2:0]       PC_SOURCE;
  logic [XLEN-1:0]  JALR;
  logic [XLEN-1:0]  BRANCH;
  logic [XLEN-1:0]  JAL;
  logic [XLEN-1:0]  MTVEC;
  logic [XLEN-1:0]  MEPC;
`ifdef PC_C_EXT_EN
  logic             IS_C;
`endif

  // instruction-memory handshake
  logic             IMEM_GNT;
  logic             IMEM_REQ;

  // PC and status
  logic [XLEN-1:0]  PC_COUNT;
  logic [XLEN-1:0]  PCAddressWithFourAdd;
  logic             PEND_VALID;
  logic             MISALIGN_ERR;
  logic [XLEN-1:0]  MISALIGN_ADDR;
  logic [CNT_W-1:0] STALL_CNT;

  modport master (
    input  PC_WRITE, PC_SOURCE, JALR, BRANCH, JAL, MTVEC, MEPC,
`ifdef PC_C_EXT_EN
    input  IS_C,
`endif
    input  IMEM_GNT,
    output IMEM_REQ, PC_COUNT, PCAddressWithFourAdd, PEND_VALID,
    output MISALIGN_ERR, MISALIGN_ADDR, STALL_CNT
  );

  modport slave (
    output PC_WRITE, PC_SOURCE, JALR, BRANCH, JAL, MTVEC, MEPC,
`ifdef PC_C_EXT_EN
    output IS_C,
`endif
    output IMEM_GNT,
    input  IMEM_REQ, PC_COUNT, PCAddressWithFourAdd, PEND_VALID,
    input  MISALIGN_ERR, MISALIGN_ADDR, STALL_CNT
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: OTTER fetch-stage program counter.
// Features:
//   - Six-source next-PC select.
//   - Request/grant handshake to instruction memory.
//   - Pending-redirect buffer, so that a redirect arriving during a fetch
//     stall is kept.
//   - Misaligned-target rejection.
//   - Saturating stall counter.
// Optional macro: PC_C_EXT_EN. It enables compressed-instruction support:
// the step becomes IS_C ? 2 : 4, and the alignment check uses bit 0 only.
module pc_fetch_ctrl #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter int              CNT_W     = 16
) (
  input  logic              clk,
  input  logic              RST_N,
  pc_fetch_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // PC_SOURCE encodings; 6 and 7 fall through as sequential
  localparam logic [2:0] SRC_SEQ    = 3'd0;
  localparam logic [2:0] SRC_JALR   = 3'd1;
  localparam logic [2:0] SRC_BRANCH = 3'd2;
  localparam logic [2:0] SRC_JAL    = 3'd3;
  localparam logic [2:0] SRC_MTVEC  = 3'd4;
  localparam logic [2:0] SRC_MEPC   = 3'd5;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // state and datapath registers
  state_t           r_state;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_pend;
  logic             r_misalign_err;
  logic [XLEN-1:0]  r_misalign_addr;
  logic [CNT_W-1:0] r_stall_cnt;

  // combinational nets
  state_t           w_state_next;
  logic [XLEN-1:0]  w_pc_next;
  logic [XLEN-1:0]  w_pend_next;
  logic [XLEN-1:0]  w_step;
  logic [XLEN-1:0]  w_pc_plus;
  logic [XLEN-1:0]  w_target;
  logic             w_src_redir;
  logic             w_src_chk;
  logic             w_src_trap;
  logic             w_misalign;
  logic             w_redir;
  logic             w_active;
  logic             w_advance;
  logic             w_imem_req;
  logic             w_pend_valid;
  logic             w_mis_evt;
  logic             w_stall_evt;

  // ---------------------------------------------------------------------
  // Step size and sequential address (wraps modulo 2^XLEN)
  // ---------------------------------------------------------------------
`ifdef PC_C_EXT_EN
  assign w_step = bus.IS_C ? XLEN'(2) : XLEN'(4);
`else
  assign w_step = XLEN'(4);
`endif
  assign w_pc_plus = r_pc + w_step;

  // Select the redirect target and classify the source
  always_comb begin
    w_target    = '0;
    w_src_redir = 1'b0;
    w_src_chk   = 1'b0;
    w_src_trap  = 1'b0;
    case (bus.PC_SOURCE)
      SRC_JALR: begin
        // JALR drops bit 0 of the computed address before use
        w_target    = {bus.JALR[XLEN-1:1], 1'b0};
        w_src_redir = 1'b1;
        w_src_chk   = 1'b1;
      end
      SRC_BRANCH: begin
        w_target    = bus.BRANCH;
        w_src_redir = 1'b1;
        w_src_chk   = 1'b1;
      end
      SRC_JAL: begin
        w_target    = bus.JAL;
        w_src_redir = 1'b1;
        w_src_chk   = 1'b1;
      end
      SRC_MTVEC: begin
        w_target    = bus.MTVEC;
        w_src_redir = 1'b1;
        w_src_trap  = 1'b1;
      end
      SRC_MEPC: begin
        w_target    = bus.MEPC;
        w_src_redir = 1'b1;
        w_src_trap  = 1'b1;
      end
      default: begin
        w_target    = '0;
      end
    endcase
  end

  // Only the address-generator sources are checked. The CSR-provided trap
  // vector and return address are taken as-is.
`ifdef PC_C_EXT_EN
  assign w_misalign = w_src_chk & w_target[0];
`else
  assign w_misalign = w_src_chk & (|w_target[1:0]);
`endif

  assign w_active    = (r_state != ST_RST);
  assign w_redir     = w_src_redir & ~w_misalign;
  assign w_advance   = w_imem_req & bus.PC_WRITE & bus.IMEM_GNT;
  assign w_mis_evt   = w_active & w_misalign;
  assign w_stall_evt = w_active & bus.PC_WRITE & ~bus.IMEM_GNT;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: a stalled redirect parks in HOLD until memory grants
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RST: begin
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!w_advance && w_redir) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // a rejected target leaves everything, including the state, untouched
        if (w_advance && !w_misalign) begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_RST;
      end
    endcase
  end

  // FSM outputs: the request is live outside reset; HOLD marks a buffered redirect
  always_comb begin
    w_imem_req   = 1'b0;
    w_pend_valid = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_imem_req = 1'b1;
      end
      ST_HOLD: begin
        w_imem_req   = 1'b1;
        w_pend_valid = 1'b1;
      end
      default: begin
        w_imem_req   = 1'b0;
        w_pend_valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // PC and pending-redirect datapath
  // ---------------------------------------------------------------------
  // Next PC and next pending target for each state
  always_comb begin
    w_pc_next   = r_pc;
    w_pend_next = r_pend;
    case (r_state)
      ST_RUN: begin
        if (w_advance) begin
          if (w_redir) begin
            w_pc_next = w_target;
          end else if (!w_misalign) begin
            w_pc_next = w_pc_plus;
          end
        end else if (w_redir) begin
          w_pend_next = w_target;
        end
      end
      ST_HOLD: begin
        if (w_advance) begin
          if (w_misalign) begin
            w_pc_next = r_pc;
          end else if (w_src_trap) begin
            // a trap entry or return beats whatever was buffered
            w_pc_next = w_target;
          end else begin
            w_pc_next = r_pend;
          end
        end else if (w_redir) begin
          // the latest redirect wins
          w_pend_next = w_target;
        end
      end
      default: begin
        w_pc_next   = r_pc;
        w_pend_next = r_pend;
      end
    endcase
  end

  // PC and pending registers; reset drops any buffered redirect
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      r_pc   <= RESET_VEC;
      r_pend <= '0;
    end else begin
      r_pc   <= w_pc_next;
      r_pend <= w_pend_next;
    end
  end

  // Misalignment reporting: one-cycle pulse, address held until the next error
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      r_misalign_err  <= 1'b0;
      r_misalign_addr <= '0;
    end else begin
      r_misalign_err <= w_mis_evt;
      if (w_mis_evt) begin
        r_misalign_addr <= w_target;
      end
    end
  end

  // Saturating count of cycles in which the core wanted to advance but memory refused
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      r_stall_cnt <= '0;
    end else if (w_stall_evt && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.IMEM_REQ             = w_imem_req;
  assign bus.PC_COUNT             = r_pc;
  assign bus.PCAddressWithFourAdd = w_pc_plus;
  assign bus.PEND_VALID           = w_pend_valid;
  assign bus.MISALIGN_ERR         = r_misalign_err;
  assign bus.MISALIGN_ADDR        = r_misalign_addr;
  assign bus.STALL_CNT            = r_stall_cnt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed test of pc_fetch_ctrl with scoreboard checking.
// The stimulus process drives one cycle at a time and queues the values it
// expects after each edge. The monitor pops and compares them on the falling edge.
// Optional macro: PC_C_EXT_EN selects the compressed-instruction variant.
module tb_pc_fetch_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    // signal selectors for scoreboard entries
    localparam int K_PC    = 0;
    localparam int K_REQ   = 1;
    localparam int K_PEND  = 2;
    localparam int K_ERR   = 3;
    localparam int K_MADDR = 4;
    localparam int K_STALL = 5;
    localparam int K_PCADD = 6;

`ifdef PC_C_EXT_EN
    localparam bit C_EN = 1'b1;
`else
    localparam bit C_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
        int          cyc;
    } item_t;

    logic  clk;
    logic  rst_n;
    int    cyc;
    int    total;
    int    bad;
    item_t sb_q[$];

    pc_fetch_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    pc_fetch_ctrl #(
        .XLEN(XLEN),
        .RESET_VEC(32'h0000_0100),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .RST_N(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] get_val(int kind);
        case (kind)
            K_PC:    return bus.PC_COUNT;
            K_REQ:   return {31'd0, bus.IMEM_REQ};
            K_PEND:  return {31'd0, bus.PEND_VALID};
            K_ERR:   return {31'd0, bus.MISALIGN_ERR};
            K_MADDR: return bus.MISALIGN_ADDR;
            K_STALL: return {28'd0, bus.STALL_CNT};
            K_PCADD: return bus.PCAddressWithFourAdd;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic void exp_push(string n, int k, logic [31:0] v);
        item_t it;
        it.name = n;
        it.kind = k;
        it.exp  = v;
        it.cyc  = cyc;
        sb_q.push_back(it);
    endfunction

    // monitor: compare every queued expectation whose cycle has been reached
    always @(negedge clk) begin
        item_t       it;
        logic [31:0] got;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            it  = sb_q.pop_front();
            got = get_val(it.kind);
            total++;
            if (got !== it.exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%h expected=%h", it.name, it.cyc, got, it.exp);
            end else begin
                $display("ok   %s cyc=%0d value=%h", it.name, it.cyc, got);
            end
        end
    end

    task automatic check_now(input string n, input int k, input logic [31:0] v);
        logic [31:0] got;
        got = get_val(k);
        total++;
        if (got !== v) begin
            bad++;
            $display("FAIL %s (now) cyc=%0d got=%h expected=%h", n, cyc, got, v);
        end else begin
            $display("ok   %s (now) cyc=%0d value=%h", n, cyc, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_req(input string n, input int max_cyc);
        int waited;
        waited = 0;
        while (bus.IMEM_REQ !== 1'b1 && waited < max_cyc) begin
            tick();
            waited++;
        end
        total++;
        if (bus.IMEM_REQ !== 1'b1) begin
            bad++;
            $display("FAIL %s cyc=%0d wait for IMEM_REQ expired after %0d cycles", n, cyc, max_cyc);
        end else begin
            $display("ok   %s cyc=%0d IMEM_REQ seen after %0d extra cycles", n, cyc, waited);
        end
    endtask

    task automatic drive(input logic pw, input logic gnt, input logic [2:0] src);
        bus.PC_WRITE  = pw;
        bus.IMEM_GNT  = gnt;
        bus.PC_SOURCE = src;
    endtask

    initial begin
        cyc   = 0;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.JALR   = '0;
        bus.BRANCH = '0;
        bus.JAL    = '0;
        bus.MTVEC  = '0;
        bus.MEPC   = '0;
`ifdef PC_C_EXT_EN
        bus.IS_C = 1'b0;
`endif
        drive(1'b1, 1'b1, 3'd0);

        // ---- reset, then sequential fetch ----
        tick();
        tick();
        check_now("rst_pc", K_PC, 32'h100);
        check_now("rst_req", K_REQ, 32'd0);
        check_now("rst_pend", K_PEND, 32'd0);
        check_now("rst_err", K_ERR, 32'd0);
        check_now("rst_maddr", K_MADDR, 32'd0);
        check_now("rst_stall", K_STALL, 32'd0);
        exp_push("rst_pc", K_PC, 32'h100);
        exp_push("rst_req", K_REQ, 32'd0);
        exp_push("rst_pend", K_PEND, 32'd0);
        exp_push("rst_err", K_ERR, 32'd0);
        exp_push("rst_maddr", K_MADDR, 32'd0);
        exp_push("rst_stall", K_STALL, 32'd0);
        rst_n = 1'b1;
        tick();
        wait_req("req_wait_release", 4);
        exp_push("req_after_release", K_REQ, 32'd1);
        exp_push("pc_after_release", K_PC, 32'h100);
        tick();
        exp_push("seq_pc1", K_PC, 32'h104);
        exp_push("seq_pcadd", K_PCADD, 32'h108);
        tick();
        exp_push("seq_pc2", K_PC, 32'h108);

        // ---- stalled branch ----
        bus.JAL = 32'h200;
        drive(1'b1, 1'b1, 3'd3);
        tick();
        exp_push("jal_to_200", K_PC, 32'h200);
        bus.BRANCH = 32'h400;
        drive(1'b1, 1'b0, 3'd2);
        tick();
        exp_push("stall_pend", K_PEND, 32'd1);
        exp_push("stall_pc_hold", K_PC, 32'h200);
        drive(1'b1, 1'b0, 3'd0);
        tick();
        tick();
        tick();
        exp_push("stall_pc_hold3", K_PC, 32'h200);
        exp_push("stall_pend3", K_PEND, 32'd1);
        drive(1'b1, 1'b1, 3'd0);
        tick();
        exp_push("grant_pc_400", K_PC, 32'h400);
        exp_push("grant_pend_clr", K_PEND, 32'd0);
        exp_push("stall_cnt4", K_STALL, 32'd4);
        tick();
        exp_push("after_grant_404", K_PC, 32'h404);

        // ---- redirect overwrite and trap override ----
        drive(1'b1, 1'b0, 3'd2);
        tick();
        bus.JAL = 32'h800;
        drive(1'b1, 1'b0, 3'd3);
        tick();
        exp_push("ovr_pend", K_PEND, 32'd1);
        bus.MTVEC = 32'h80;
        drive(1'b1, 1'b1, 3'd4);
        tick();
        exp_push("trap_override_pc", K_PC, 32'h80);
        exp_push("trap_pend_clr", K_PEND, 32'd0);
        // overwritten pending target is the one taken on a plain grant
        bus.JALR = 32'h501;
        drive(1'b1, 1'b0, 3'd1);
        tick();
        bus.BRANCH = 32'h600;
        drive(1'b1, 1'b0, 3'd2);
        tick();
        exp_push("hold_no_seq_step", K_PC, 32'h80);
        drive(1'b1, 1'b1, 3'd0);
        tick();
        exp_push("latest_redirect_wins", K_PC, 32'h600);
        exp_push("stall_cnt8", K_STALL, 32'd8);

        // ---- misaligned target ----
        bus.JAL = 32'h300;
        drive(1'b1, 1'b1, 3'd3);
        tick();
        bus.JAL = 32'h302;
        drive(1'b1, 1'b1, 3'd3);
        tick();
        exp_push("mis_pc", K_PC, C_EN ? 32'h302 : 32'h300);
        exp_push("mis_err", K_ERR, C_EN ? 32'd0 : 32'd1);
        exp_push("mis_addr", K_MADDR, C_EN ? 32'd0 : 32'h302);
        bus.JALR = 32'h305;
        drive(1'b1, 1'b1, 3'd1);
        tick();
        exp_push("jalr_clear_bit0", K_PC, 32'h304);
        exp_push("err_one_cycle", K_ERR, 32'd0);
        exp_push("maddr_holds", K_MADDR, C_EN ? 32'd0 : 32'h302);
        drive(1'b1, 1'b1, 3'd0);
        tick();
        exp_push("seq_after_jalr", K_PC, 32'h308);

        // ---- wrap ----
        bus.MEPC = 32'hFFFF_FFFC;
        drive(1'b1, 1'b1, 3'd5);
        tick();
        exp_push("mepc_pc", K_PC, 32'hFFFF_FFFC);
        exp_push("wrap_pcadd", K_PCADD, 32'h0);
        drive(1'b1, 1'b1, 3'd7);
        tick();
        exp_push("wrap_pc0", K_PC, 32'h0);

        // ---- saturation ----
        drive(1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 20; i++) tick();
        exp_push("stall_sat", K_STALL, 32'd15);
        exp_push("stall_pc_hold", K_PC, 32'h0);

        // ---- reset while in HOLD ----
        bus.BRANCH = 32'h700;
        drive(1'b1, 1'b0, 3'd2);
        tick();
        exp_push("hold_before_rst", K_PEND, 32'd1);
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 3'd0);
        tick();
        check_now("rst_hold_pend", K_PEND, 32'd0);
        check_now("rst_hold_pc", K_PC, 32'h100);
        exp_push("rst_hold_pend", K_PEND, 32'd0);
        exp_push("rst_hold_pc", K_PC, 32'h100);
        exp_push("rst_hold_stall", K_STALL, 32'd0);
        exp_push("rst_hold_req", K_REQ, 32'd0);
        rst_n = 1'b1;
        tick();
        wait_req("req_wait_rerun", 4);
        exp_push("rerun_req", K_REQ, 32'd1);
        tick();
        exp_push("pending_discarded", K_PC, 32'h104);
        drive(1'b0, 1'b1, 3'd0);
        tick();
        exp_push("no_pc_write_hold", K_PC, 32'h104);

`ifdef PC_C_EXT_EN
        // ---- compressed step and 2-byte alignment ----
        bus.JAL = 32'h100;
        drive(1'b1, 1'b1, 3'd3);
        tick();
        bus.IS_C = 1'b1;
        drive(1'b1, 1'b1, 3'd0);
        tick();
        exp_push("c_step2", K_PC, 32'h102);
        bus.IS_C = 1'b0;
        bus.JAL  = 32'h106;
        drive(1'b1, 1'b1, 3'd3);
        tick();
        exp_push("c_jal_106", K_PC, 32'h106);
        exp_push("c_jal_106_err", K_ERR, 32'd0);
        bus.JAL = 32'h107;
        tick();
        exp_push("c_jal_107_pc", K_PC, 32'h106);
        exp_push("c_jal_107_err", K_ERR, 32'd1);
        exp_push("c_jal_107_addr", K_MADDR, 32'h107);
`endif

        drive(1'b1, 1'b1, 3'd0);
        tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Parametrised program-counter unit for the OTTER fetch stage. It replaces the fixed 4-source PC mux and register with the following:
- a 6-source next-PC select that includes the trap vector and the trap return address;
- a request/grant handshake to instruction memory;
- a pending-redirect buffer, so branch and jump targets are not lost while fetch is stalled;
- misaligned-target detection;
- a stall-cycle counter.

It sits between the branch/jump address generators, the CSR unit (MTVEC/MEPC) and the instruction-memory port.

Parameters:
XLEN, 32, width of the PC and of all address ports.
RESET_VEC, 32'h0000_0000, PC value loaded on reset.
CNT_W, 16, width of the saturating stall counter.

Ports:
clk  in  1  system clock, rising edge.
RST_N  in  1  reset, synchronous, active-low.
PC_WRITE  in  1  core permits the PC to advance this cycle.
PC_SOURCE  in  3  0=PC+4, 1=JALR, 2=BRANCH, 3=JAL, 4=MTVEC, 5=MEPC, 6/7 reserved (treated as 0).
JALR  in  XLEN  JALR target.
BRANCH  in  XLEN  branch target.
JAL  in  XLEN  JAL target.
MTVEC  in  XLEN  trap vector.
MEPC  in  XLEN  trap return address.
IMEM_GNT  in  1  instruction memory accepts the current request.
IMEM_REQ  out  1  fetch request valid.
PC_COUNT  out  XLEN  current PC; also the fetch address.
PCAddressWithFourAdd  out  XLEN  PC_COUNT + step (step defined below), combinational.
PEND_VALID  out  1  a redirect is buffered.
MISALIGN_ERR  out  1  one-cycle pulse: rejected misaligned target.
MISALIGN_ADDR  out  XLEN  last rejected target; holds its value until the next error.
STALL_CNT  out  CNT_W  cycles with PC_WRITE=1 and IMEM_GNT=0, saturating.

Behaviour:
- Reset is synchronous: clk rising edge with RST_N=0 gives PC_COUNT=RESET_VEC, IMEM_REQ=0, PEND_VALID=0, MISALIGN_ERR=0, MISALIGN_ADDR=0, STALL_CNT=0, state=RST. A reset applied mid-stall or mid-HOLD discards the pending redirect.
- Step is 4 (see the optional feature). All additions wrap modulo 2^XLEN with no carry out; PC=FFFF_FFFC + 4 gives 0.
- The JALR target has bit 0 cleared before use. The alignment check applies to sources 1–3 only: the target is misaligned if bits[1:0] != 0. MTVEC and MEPC are trusted.
- advance = IMEM_REQ & PC_WRITE & IMEM_GNT.
- redir = PC_SOURCE in {1..5} and the target is aligned.
- A misaligned request (sources 1–3) does not update the PC or the pending buffer. It sets MISALIGN_ERR=1 for one cycle and loads MISALIGN_ADDR with the target.
- FSM states: RST, RUN, HOLD. IMEM_REQ = (state != RST).
- RST:
  - Exits to RUN on the first edge with RST_N=1.
  - The PC stays at RESET_VEC.
  - The first request is issued in the following cycle, so latency from reset release to IMEM_REQ is 1 cycle.
- RUN:
  - advance: PC <= redir ? target : PC+step; stay in RUN.
  - !advance & redir: pending <= target; go to HOLD; PC unchanged.
  - !advance & !redir: hold.
- HOLD:
  - PEND_VALID=1.
  - advance: PC <= pending; go to RUN. Exception: if PC_SOURCE is 4 or 5 in the same cycle, PC <= that target, because the trap overrides the buffer.
  - !advance & redir: pending is overwritten by the new target; the latest redirect wins.
  - PC_SOURCE=0 in HOLD never produces a sequential step.
- Redirect latency: the PC updates on the edge where advance=1. There is no bubble inserted by this block.
- STALL_CNT increments when state != RST & PC_WRITE & !IMEM_GNT, and saturates at 2^CNT_W-1.

Optional Feature:
Macro PC_C_EXT_EN (RISC-V compressed-instruction support).
- Defined:
  - Adds input IS_C (1 bit): the current instruction is 16-bit.
  - step = IS_C ? 2 : 4.
  - Misalignment is checked on bit[0] only, so targets on 2-byte boundaries are legal.
- Undefined:
  - No IS_C port.
  - step = 4.
  - Misalignment is checked on bits[1:0].

Test Plan:
- Reset and sequential fetch: RESET_VEC=0x100. Hold RST_N=0 for 2 cycles, then release with PC_WRITE=1, IMEM_GNT=1, PC_SOURCE=0. Expect IMEM_REQ to rise 1 cycle after release, then PC_COUNT=0x100, 0x104, 0x108 on successive edges.
- Stalled branch: at PC=0x200, set IMEM_GNT=0, PC_SOURCE=2, BRANCH=0x400 for 1 cycle, then PC_SOURCE=0 for 3 cycles, then IMEM_GNT=1. Expect PEND_VALID=1 and PC held at 0x200 during the stall. On the grant edge PC=0x400, then 0x404. STALL_CNT=4.
- Redirect overwrite and trap override: in HOLD with pending=0x400, apply JAL=0x800 while stalled. On the grant edge, drive PC_SOURCE=4 with MTVEC=0x80. Expect PC=0x80, not 0x800.
- Misaligned target: at PC=0x300, apply JAL=0x302 with advance=1. Expect PC=0x300 unchanged, a 1-cycle MISALIGN_ERR pulse and MISALIGN_ADDR=0x302. With JALR=0x305, expect PC=0x304 and no error.
- Wrap and saturation: from PC=0xFFFF_FFFC, apply a sequential step and expect PC=0. With CNT_W=4, run 20 stall cycles and expect STALL_CNT=15. Assert RST_N=0 in HOLD and expect PEND_VALID=0 and PC=RESET_VEC.
- With PC_C_EXT_EN defined: at PC=0x100 with IS_C=1, expect PC=0x102. JAL=0x106 is accepted; JAL=0x107 raises MISALIGN_ERR.
